// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, 16550-style LSR bit positions
// and the default bit period used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Positions within the 32-bit status word returned on the bus.
  localparam int LSR_DR   = 8;
  localparam int LSR_OE   = 9;
  localparam int LSR_FE   = 11;
  localparam int LSR_THRE = 13;
  localparam int LSR_TEMT = 14;
  localparam int RX_FULL  = 16;

  localparam int DEFAULT_BIT_TIME = 433;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with show-ahead read data; push and pop may occur
// in the same cycle, including when the FIFO is full.
module uart_rx_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;

  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a word-bus slave port and LSR-style status.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_TIME        = DEFAULT_BIT_TIME,
  parameter int HALF_TIME       = BIT_TIME / 2,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [3:0]  lane,
  input  logic        wr,
  input  logic        valid,
  input  logic        rxd,
  output logic        irq
);

  localparam int TW = (BIT_TIME > 0) ? $clog2(BIT_TIME + 1) : 1;

  // Bus access: a cycle with valid high is one complete access (no wait
  // states); read data appears on dout the following cycle, writes are ignored.
  logic data_rd, stat_rd;
  assign data_rd = valid & ~wr & ~addr[2];
  assign stat_rd = valid & ~wr &  addr[2];

  logic unused_ok;
  assign unused_ok = ^{din, lane, addr[1:0], 1'(FIFO_DEPTH_LOG2)};

  logic rx_meta, rxs;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  rx_state_t   state, state_d;
  logic [TW-1:0] tdiv, tdiv_d;
  logic [2:0]  bidx, bidx_d;
  logic [7:0]  shreg, shreg_d;
  logic        deliver, fe_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      tdiv  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      tdiv  <= tdiv_d;
      bidx  <= bidx_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d = state;
    tdiv_d  = tdiv;
    bidx_d  = bidx;
    shreg_d = shreg;
    deliver = 1'b0;
    fe_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        tdiv_d = '0;
        // The counter advances on the detection edge, so the mid-point
        // check lands HALF_TIME cycles after the start bit is seen.
        if (!rxs) begin
          state_d = S_START;
          tdiv_d  = TW'(1);
        end
      end
      S_START: begin
        tdiv_d = tdiv + TW'(1);
        if (tdiv == TW'(HALF_TIME)) begin
          tdiv_d  = '0;
          bidx_d  = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        tdiv_d = (tdiv == TW'(BIT_TIME)) ? '0 : tdiv + TW'(1);
        if (tdiv == TW'(BIT_TIME)) begin
          shreg_d = {rxs, shreg[7:1]};
          bidx_d  = bidx + 3'd1;
          if (bidx == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        tdiv_d = (tdiv == TW'(BIT_TIME)) ? '0 : tdiv + TW'(1);
        if (tdiv == TW'(BIT_TIME)) begin
          deliver = 1'b1;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        tdiv_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tdiv_d  = '0;
      end
    endcase
  end

  logic        ready, full_bit, overrun;
  logic [31:0] data_word;

`ifdef UART_RX_FIFO_EN
  logic       f_push, f_pop, f_full, f_empty;
  logic [7:0] f_rdata;

  assign f_pop     = data_rd & ~f_empty;
  assign f_push    = deliver & (~f_full | f_pop);
  assign overrun   = deliver & f_full & ~f_pop;
  assign ready     = ~f_empty;
  assign full_bit  = f_full;
  assign data_word = f_empty ? 32'h0 : {24'h0, f_rdata};

  uart_rx_fifo #(
    .W          (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .wdata (shreg),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );
`else
  logic [7:0] hold;

  // A same-cycle data read frees the register, so the new byte still loads.
  assign overrun   = deliver & ready & ~data_rd;
  assign full_bit  = 1'b0;
  assign data_word = {24'h0, hold};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold  <= '0;
      ready <= 1'b0;
    end else if (deliver && (!ready || data_rd)) begin
      hold  <= shreg;
      ready <= 1'b1;
    end else if (data_rd) begin
      ready <= 1'b0;
    end
  end
`endif

  logic oe, fe;
  logic [31:0] status_word;

  always_comb begin
    status_word          = '0;
    status_word[LSR_DR]  = ready;
    status_word[LSR_OE]  = oe;
    status_word[LSR_FE]  = fe;
    status_word[RX_FULL] = full_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe   <= 1'b0;
      fe   <= 1'b0;
      dout <= '0;
      irq  <= 1'b0;
    end else begin
      // Flag sets take priority over the clearing status read.
      if (overrun)      oe <= 1'b1;
      else if (stat_rd) oe <= 1'b0;
      if (fe_set)       fe <= 1'b1;
      else if (stat_rd) fe <= 1'b0;
      if (data_rd)      dout <= data_word;
      else if (stat_rd) dout <= status_word;
      else              dout <= '0;
      irq <= ready;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx; follows UART_RX_FIFO_EN like the RTL.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BT = 15;
  localparam int HT = 7;
`ifdef UART_RX_FIFO_EN
  localparam int CAP     = 16;
  localparam bit HAS_FIFO = 1'b1;
`else
  localparam int CAP     = 1;
  localparam bit HAS_FIFO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  lane;
  logic        wr;
  logic        valid;
  logic        rxd;
  logic        irq;

  uart_rx #(
    .BIT_TIME        (BT),
    .HALF_TIME       (HT),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .lane  (lane),
    .wr    (wr),
    .valid (valid),
    .rxd   (rxd),
    .irq   (irq)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: received bytes as a bounded queue plus sticky flags.
  logic [7:0] mq[$];
  bit         m_oe, m_fe;
  logic [7:0] m_hold;

  function automatic void model_reset();
    mq.delete();
    m_oe   = 1'b0;
    m_fe   = 1'b0;
    m_hold = 8'h00;
  endfunction

  function automatic void model_deliver(input logic [7:0] b, input bit stop_ok);
    if (mq.size() < CAP) begin
      mq.push_back(b);
      m_hold = b;
    end else begin
      m_oe = 1'b1;
    end
    if (!stop_ok) m_fe = 1'b1;
  endfunction

  function automatic logic [31:0] model_data_read();
    if (mq.size() > 0) return {24'h0, mq.pop_front()};
    return HAS_FIFO ? 32'h0 : {24'h0, m_hold};
  endfunction

  function automatic logic [31:0] model_status_read();
    logic [31:0] s;
    s = 32'h0;
    s[16] = HAS_FIFO && (mq.size() == CAP);
    s[11] = m_fe;
    s[9]  = m_oe;
    s[8]  = (mq.size() > 0);
    m_oe = 1'b0;
    m_fe = 1'b0;
    return s;
  endfunction

  // Monitor: any bus access presents its result on dout one cycle later.
  logic acc_q = 1'b0, acc_rd_q = 1'b0;
  always @(posedge clk) begin
    acc_q    <= valid;
    acc_rd_q <= valid & ~wr;
  end

  always @(negedge clk) begin
    if (acc_q) begin
      if (acc_rd_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got %h expected no read", dout);
        end else begin
          check("read_dout", dout, exp_q.pop_front());
        end
      end else begin
        check("write_dout", dout, 32'h0);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int low_stop_bits);
    rxd = 1'b0;
    tick(BT + 1);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BT + 1);
    end
    if (low_stop_bits > 0) begin
      rxd = 1'b0;
      tick(low_stop_bits * (BT + 1));
      rxd = 1'b1;
      tick(BT + 5);
    end else begin
      rxd = 1'b1;
      tick(BT + 1);
    end
    model_deliver(b, low_stop_bits == 0);
  endtask

  task automatic bus_read(input bit is_status);
    exp_q.push_back(is_status ? model_status_read() : model_data_read());
    valid = 1'b1;
    wr    = 1'b0;
    addr  = {is_status, 2'b00};
    tick(1);
    valid = 1'b0;
    addr  = 3'd0;
    tick(1);
  endtask

  task automatic bus_write(input bit is_status);
    valid = 1'b1;
    wr    = 1'b1;
    addr  = {is_status, 2'b00};
    din   = $urandom;
    lane  = 4'hF;
    tick(1);
    valid = 1'b0;
    wr    = 1'b0;
    lane  = 4'h0;
    tick(1);
  endtask

  task automatic check_irq(input string name);
    tick(3);
    @(negedge clk);
    check(name, {31'h0, irq}, {31'h0, mq.size() > 0});
    tick(0);
  endtask

  initial begin
    logic [7:0] b;
    int low;
    reset = 1'b1;
    rxd   = 1'b1;
    valid = 1'b0;
    wr    = 1'b0;
    addr  = 3'd0;
    din   = 32'h0;
    lane  = 4'h0;
    model_reset();
    tick(3);
    @(negedge clk);
    check("reset_dout", dout, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_state", 32'(dut.state), 32'(S_IDLE));
    tick(0);
    reset = 1'b0;
    tick(5);

    // Clean frame, then read it back
    send_frame(8'hA5, 0);
    check_irq("irq_after_a5");
    bus_read(1'b0);
    check_irq("irq_after_read_a5");
    bus_read(1'b1);

    // Short low glitches must be rejected at the mid-point check
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      tick(1);
      rxd = 1'b1;
      tick(3);
    end
    tick(40);
    @(negedge clk);
    check("glitch_state", 32'(dut.state), 32'(S_IDLE));
    tick(0);
    bus_read(1'b1);
    check_irq("glitch_irq");

    // Stop bit held low: one byte, one framing error
    send_frame(8'h3C, 3);
    bus_read(1'b1);
    bus_read(1'b0);
    bus_read(1'b1);

`ifdef UART_RX_FIFO_EN
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0);
    bus_read(1'b1);
    for (int i = 0; i < 16; i++) bus_read(1'b0);
    check_irq("fifo_drained_irq");
    bus_read(1'b0);
`else
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    bus_read(1'b1);
    bus_read(1'b0);
    bus_read(1'b1);
`endif

    // Writes have no effect
    send_frame(8'h5A, 0);
    bus_write(1'b0);
    bus_write(1'b1);
    bus_read(1'b1);
    bus_read(1'b0);

    // Reset in the middle of data bit 4
    b = 8'h55;
    rxd = 1'b0;
    tick(BT + 1);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      tick(BT + 1);
    end
    rxd = b[4];
    tick(8);
    reset = 1'b1;
    model_reset();
    tick(2);
    rxd = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2 * (BT + 1));
    send_frame(8'h66, 0);
    bus_read(1'b1);
    bus_read(1'b0);
    bus_read(1'b1);

    // Random frames, breaks and reads
    for (int n = 0; n < 14; n++) begin
      b   = 8'($urandom_range(0, 255));
      low = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(b, low);
      tick($urandom_range(0, 20));
      case ($urandom_range(0, 3))
        1: bus_read(1'b0);
        2: bus_read(1'b1);
        3: begin
          bus_read(1'b1);
          bus_read(1'b0);
          check_irq("rand_irq");
        end
        default: ;
      endcase
    end
    while (mq.size() > 0) bus_read(1'b0);
    bus_read(1'b1);
    check_irq("final_irq");

    tick(5);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
